vga_palette_ram: RTL and testbench
==================================

// Module: vga_palette_ram
// PURPOSE
//  Writable, multi-port colour palette for the VGA pipeline; replaces the fixed 16-entry ROM palette.
//  Maps NUM_RD pixel colour indices to COLOR_W-bit RGB values per cycle; CPU can rewrite entries via MMIO.
//  Self-loads the default 16-colour CGA palette after reset or on request. Sits between the text/attr
//  fetch stage and the VGA DAC output register.
// PARAMETERS
//  ADDR_W   4  index width; palette depth = 2**ADDR_W entries
//  COLOR_W  8  colour width (RGB332 at 8)
//  NUM_RD   2  number of independent read ports (fg/bg, or more for sprites)
// PORTS
//  clk      in   1               system clock; single clock domain
//  rst      in   1               asynchronous, active-high reset
//  restore  in   1               1-cycle pulse: reload default palette
//  wr_en    in   1               CPU write strobe
//  wr_addr  in   ADDR_W          CPU write index
//  wr_data  in   COLOR_W         CPU write colour
//  wr_ready out  1               1 = writes accepted (idle); 0 during load
//  rd_addr  in   NUM_RD*ADDR_W   packed read indices, port k = [k*ADDR_W +: ADDR_W]
//  color    out  NUM_RD*COLOR_W  packed registered colours, port k = [k*COLOR_W +: COLOR_W]
//  busy     out  1               1 while default palette is being loaded
// BEHAVIOUR
//  Reset (async assert): color=0, busy=1, wr_ready=0, FSM=LOAD, load counter=0. Memory array not reset.
//  FSM LOAD: one entry per cycle, mem[cnt] <= DEFAULT(cnt); cnt wraps at 2**ADDR_W-1 -> IDLE.
//   Load takes exactly 2**ADDR_W cycles after rst deasserts; busy drops the cycle after last entry written.
//  FSM IDLE: busy=0, wr_ready=1. restore=1 -> LOAD with cnt=0 (next cycle busy=1).
//  DEFAULT(i): i<16 -> CGA table {00,02,14,16,A0,A2,A8,B6,49,4B,5D,5F,E9,EB,FD,FF} (hex, RGB332);
//   COLOR_W<8 keeps low COLOR_W bits, COLOR_W>8 zero-extends; i>=16 -> 0.
//  Writes: wr_en && wr_ready -> mem[wr_addr] <= wr_data at clk edge. wr_en while busy: dropped, no error.
//  restore and wr_en same cycle in IDLE: restore wins, write dropped.
//  Reads: 1-cycle latency; color[k] at edge N+1 = mem[rd_addr[k]] sampled at edge N.
//   Write bypass: if wr accepted with wr_addr == rd_addr[k] in same cycle, color[k] returns wr_data.
//   All ports may read the same index simultaneously; no port conflicts.
//   While busy: color forced to 0 (blank) regardless of rd_addr.
//  restore asserted during LOAD: ignored (load continues, no restart). rst mid-LOAD: restart from cnt=0.
//  Widths: cnt is ADDR_W bits plus terminal detect; no arithmetic beyond increment.
// STRUCTURE
//  Shared package vga_pkg: CGA_DEFAULT[0:15] 8-bit constant table, PAL_LOAD/PAL_IDLE state encodings.
//  Sub-module vga_palette_loader: LOAD/IDLE FSM + counter; outputs ld_we, ld_addr, ld_data, busy.
//  Top: storage array (reg or inferred LUTRAM, NUM_RD read ports), write mux (loader vs CPU), read regs.
// TESTING
//  1 rst pulse, release -> busy=1 for exactly 16 cycles, then wr_ready=1; read idx 4 -> A0, idx 15 -> FF.
//  2 IDLE: write idx 3 = 0x5A, read port0 idx3 same cycle -> color0=0x5A next cycle (bypass); port1 idx2 -> 14.
//  3 wr_en idx1=0x77 during load cycle 5 -> dropped; after load idx1 reads 02.
//  4 write idx7=0x00, pulse restore -> busy 16 cycles, color=0 throughout; then idx7 reads B6.
//  5 restore + wr_en idx9=0x33 same IDLE cycle -> after reload idx9 reads 4B; rst at load cycle 8 -> 16 more cycles.
//  6 ADDR_W=5, COLOR_W=6, NUM_RD=4 -> 32-cycle load; idx4 reads 0x20, idx20 reads 0; all 4 ports independent.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared definitions for the VGA palette: loader state encoding and the
// default 16-colour CGA table in RGB332.
package vga_pkg;

   typedef enum logic {
      PAL_LOAD = 1'b0,
      PAL_IDLE = 1'b1
   } pal_state_e;

   localparam int unsigned CGA_N = 16;

   localparam logic [7:0] CGA_DEFAULT [0:15] = '{
      8'h00, 8'h02, 8'h14, 8'h16, 8'hA0, 8'hA2, 8'hA8, 8'hB6,
      8'h49, 8'h4B, 8'h5D, 8'h5F, 8'hE9, 8'hEB, 8'hFD, 8'hFF
   };

   // Entries beyond the CGA table default to black.
   function automatic logic [7:0] cga_default(input int unsigned idx);
      logic [7:0] val;
      val = 8'h00;
      if (idx < CGA_N) val = CGA_DEFAULT[idx[3:0]];
      return val;
   endfunction

endpackage

// File: rtl/vga_palette_loader.sv
// Default-palette loader: walks every palette index once after reset or on a
// restore request, emitting one write per cycle while busy is high.
module vga_palette_loader
   import vga_pkg::*;
#(
   parameter int ADDR_W  = 4,
   parameter int COLOR_W = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               restore,
   output logic               ld_we,
   output logic [ADDR_W-1:0]  ld_addr,
   output logic [COLOR_W-1:0] ld_data,
   output logic               busy
);

   pal_state_e          state_q, state_d;
   logic [ADDR_W-1:0]   cnt_q, cnt_d;
   logic                cnt_last;
   logic [COLOR_W+7:0]  dflt_ext;

   assign cnt_last = &cnt_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= PAL_LOAD;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // restore is only honoured from IDLE; a running load is never restarted by it.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         PAL_LOAD: begin
            cnt_d = cnt_q + ADDR_W'(1);
            if (cnt_last) state_d = PAL_IDLE;
         end
         PAL_IDLE: begin
            if (restore) begin
               state_d = PAL_LOAD;
               cnt_d   = '0;
            end
         end
      endcase
   end

   // Zero-extend then slice so narrow colours keep the low bits and wide ones get zero MSBs.
   assign dflt_ext = {COLOR_W'(0), cga_default(32'(cnt_q))};

   assign busy    = (state_q == PAL_LOAD);
   assign ld_we   = busy;
   assign ld_addr = cnt_q;
   assign ld_data = dflt_ext[COLOR_W-1:0];

endmodule

// File: rtl/vga_palette_ram.sv
// Writable multi-port colour palette: CPU-writable storage, self-loading CGA
// defaults, NUM_RD registered read ports with write-through bypass.
module vga_palette_ram
   import vga_pkg::*;
#(
   parameter int ADDR_W  = 4,
   parameter int COLOR_W = 8,
   parameter int NUM_RD  = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       restore,
   input  logic                       wr_en,
   input  logic [ADDR_W-1:0]          wr_addr,
   input  logic [COLOR_W-1:0]         wr_data,
   output logic                       wr_ready,
   input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
   output logic [NUM_RD*COLOR_W-1:0]  color,
   output logic                       busy
);

   localparam int DEPTH = 2 ** ADDR_W;

   logic [COLOR_W-1:0]        mem_q [DEPTH];
   logic                      ld_we;
   logic [ADDR_W-1:0]         ld_addr;
   logic [COLOR_W-1:0]        ld_data;
   logic                      cpu_we;
   logic [NUM_RD*COLOR_W-1:0] color_q, color_d;

   vga_palette_loader #(
      .ADDR_W  (ADDR_W),
      .COLOR_W (COLOR_W)
   ) u_loader (
      .clk     (clk),
      .rst     (rst),
      .restore (restore),
      .ld_we   (ld_we),
      .ld_addr (ld_addr),
      .ld_data (ld_data),
      .busy    (busy)
   );

   assign wr_ready = ~busy;
   // A restore in the same cycle takes priority and discards the CPU write.
   assign cpu_we   = wr_en & wr_ready & ~restore;

   always_ff @(posedge clk) begin
      if (ld_we) begin
         mem_q[ld_addr] <= ld_data;
      end else if (cpu_we) begin
         mem_q[wr_addr] <= wr_data;
      end
   end

   always_comb begin
      color_d = '0;
      if (!busy) begin
         for (int k = 0; k < NUM_RD; k++) begin
            if (cpu_we && (wr_addr == rd_addr[k*ADDR_W +: ADDR_W])) begin
               color_d[k*COLOR_W +: COLOR_W] = wr_data;
            end else begin
               color_d[k*COLOR_W +: COLOR_W] = mem_q[rd_addr[k*ADDR_W +: ADDR_W]];
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         color_q <= '0;
      end else begin
         color_q <= color_d;
      end
   end

   // Blank immediately when a load starts rather than one cycle later.
   assign color = busy ? '0 : color_q;

endmodule

// File: tb/tb_vga_palette_ram.sv
// Self-checking bench for vga_palette_ram: directed scenarios plus randomized
// traffic checked against a behavioural palette model.
module tb_vga_palette_ram;

   localparam int AW = 4, CW = 8, NR = 2, DEPTH = 16;
   localparam int AW2 = 5, CW2 = 6, NR2 = 4, DEPTH2 = 32;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              rst, restore, wr_en, wr_ready, busy;
   logic [AW-1:0]     wr_addr;
   logic [CW-1:0]     wr_data;
   logic [NR*AW-1:0]  rd_addr;
   logic [NR*CW-1:0]  color;

   logic               rst_b, restore_b, wr_en_b, wr_ready_b, busy_b;
   logic [AW2-1:0]     wr_addr_b;
   logic [CW2-1:0]     wr_data_b;
   logic [NR2*AW2-1:0] rd_addr_b;
   logic [NR2*CW2-1:0] color_b;

   int passed = 0;
   int total  = 0;

   logic [7:0] cga [16] = '{8'h00, 8'h02, 8'h14, 8'h16, 8'hA0, 8'hA2, 8'hA8, 8'hB6,
                            8'h49, 8'h4B, 8'h5D, 8'h5F, 8'hE9, 8'hEB, 8'hFD, 8'hFF};

   // Reference model for the default instance
   logic [CW-1:0] m_mem [DEPTH];
   int            m_left;
   logic [CW-1:0] m_col [NR];

   vga_palette_ram #(.ADDR_W(AW), .COLOR_W(CW), .NUM_RD(NR)) dut (
      .clk(clk), .rst(rst), .restore(restore), .wr_en(wr_en), .wr_addr(wr_addr),
      .wr_data(wr_data), .wr_ready(wr_ready), .rd_addr(rd_addr), .color(color), .busy(busy));

   vga_palette_ram #(.ADDR_W(AW2), .COLOR_W(CW2), .NUM_RD(NR2)) dut_b (
      .clk(clk), .rst(rst_b), .restore(restore_b), .wr_en(wr_en_b), .wr_addr(wr_addr_b),
      .wr_data(wr_data_b), .wr_ready(wr_ready_b), .rd_addr(rd_addr_b), .color(color_b), .busy(busy_b));

   task automatic model_reload();
      for (int i = 0; i < DEPTH; i++) m_mem[i] = cga[i];
      m_left = DEPTH;
      for (int k = 0; k < NR; k++) m_col[k] = '0;
   endtask

   // Advance model by one clock using the inputs currently applied, then step the DUT.
   task automatic cycle();
      logic [CW-1:0] nxt [NR];
      logic [AW-1:0] ra;
      for (int k = 0; k < NR; k++) nxt[k] = '0;
      if (rst) begin
         model_reload();
      end else if (m_left > 0) begin
         m_left = m_left - 1;
      end else begin
         for (int k = 0; k < NR; k++) begin
            ra = rd_addr[k*AW +: AW];
            nxt[k] = (wr_en && !restore && wr_addr == ra) ? wr_data : m_mem[ra];
         end
         if (restore) model_reload();
         else if (wr_en) m_mem[wr_addr] = wr_data;
      end
      for (int k = 0; k < NR; k++) m_col[k] = nxt[k];
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      int n;
      rst = 1'b1; restore = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; rd_addr = '0;
      model_reload();
      cycle(); cycle();
      total++; if (color !== '0) $display("FAIL reset_color got=%h want=0", color); else passed++;
      total++; if (busy !== 1'b1) $display("FAIL reset_busy got=%b want=1", busy); else passed++;
      total++; if (wr_ready !== 1'b0) $display("FAIL reset_wr_ready got=%b want=0", wr_ready); else passed++;
      rst = 1'b0;
      n = 0;
      while (busy === 1'b1 && n < 40) begin cycle(); n++; end
      total++; if (n != 16) $display("FAIL reset_load_len got=%0d want=16", n); else passed++;
      total++; if (wr_ready !== 1'b1) $display("FAIL reset_idle_ready got=%b want=1", wr_ready); else passed++;
      rd_addr = {4'd15, 4'd4};
      cycle();
      total++; if (color[7:0] !== 8'hA0) $display("FAIL reset_idx4 got=%h want=a0", color[7:0]); else passed++;
      total++; if (color[15:8] !== 8'hFF) $display("FAIL reset_idx15 got=%h want=ff", color[15:8]); else passed++;
   endtask

   task automatic test_bypass();
      wr_en = 1'b1; wr_addr = 4'd3; wr_data = 8'h5A; rd_addr = {4'd2, 4'd3};
      cycle();
      wr_en = 1'b0;
      total++; if (color[7:0] !== 8'h5A) $display("FAIL bypass_p0 got=%h want=5a", color[7:0]); else passed++;
      total++; if (color[15:8] !== 8'h14) $display("FAIL bypass_p1 got=%h want=14", color[15:8]); else passed++;
      cycle();
      total++; if (color[7:0] !== 8'h5A) $display("FAIL stored_p0 got=%h want=5a", color[7:0]); else passed++;
   endtask

   task automatic test_write_during_load();
      int n;
      rst = 1'b1; cycle(); rst = 1'b0;
      for (int i = 0; i < 4; i++) cycle();
      wr_en = 1'b1; wr_addr = 4'd1; wr_data = 8'h77;
      total++; if (wr_ready !== 1'b0) $display("FAIL load_wr_ready got=%b want=0", wr_ready); else passed++;
      cycle();
      wr_en = 1'b0;
      n = 0;
      while (busy === 1'b1 && n < 40) begin cycle(); n++; end
      total++; if (busy !== 1'b0) $display("FAIL load_drop_timeout got=%b want=0", busy); else passed++;
      rd_addr = {4'd0, 4'd1};
      cycle();
      total++; if (color[7:0] !== 8'h02) $display("FAIL load_drop_idx1 got=%h want=02", color[7:0]); else passed++;
   endtask

   task automatic test_restore();
      int bad;
      wr_en = 1'b1; wr_addr = 4'd7; wr_data = 8'h00; cycle(); wr_en = 1'b0;
      rd_addr = {4'd7, 4'd7};
      restore = 1'b1; cycle(); restore = 1'b0;
      bad = 0;
      for (int i = 0; i < 16; i++) begin
         if (busy !== 1'b1 || color !== '0) bad++;
         cycle();
      end
      total++; if (bad != 0) $display("FAIL restore_blank got=%0d bad cycles want=0", bad); else passed++;
      total++; if (busy !== 1'b0) $display("FAIL restore_len got=%b want=0", busy); else passed++;
      cycle();
      total++; if (color[7:0] !== 8'hB6) $display("FAIL restore_idx7 got=%h want=b6", color[7:0]); else passed++;
   endtask

   task automatic test_restore_collide();
      int n;
      restore = 1'b1; wr_en = 1'b1; wr_addr = 4'd9; wr_data = 8'h33;
      cycle();
      restore = 1'b0; wr_en = 1'b0;
      n = 0;
      while (busy === 1'b1 && n < 40) begin cycle(); n++; end
      rd_addr = {4'd9, 4'd0};
      cycle();
      total++; if (color[15:8] !== 8'h4B) $display("FAIL collide_idx9 got=%h want=4b", color[15:8]); else passed++;
      // restore inside a load must not extend it
      restore = 1'b1; cycle(); restore = 1'b0;
      n = 0;
      while (busy === 1'b1 && n < 40) begin
         if (n == 5) restore = 1'b1;
         cycle();
         restore = 1'b0;
         n++;
      end
      total++; if (n != 16) $display("FAIL restore_in_load got=%0d want=16", n); else passed++;
      // rst eight cycles into a load restarts it
      restore = 1'b1; cycle(); restore = 1'b0;
      for (int i = 0; i < 8; i++) cycle();
      rst = 1'b1;
      #1;
      total++; if (busy !== 1'b1 || color !== '0) $display("FAIL midload_rst got=%b/%h want=1/0", busy, color); else passed++;
      cycle();
      rst = 1'b0;
      n = 0;
      while (busy === 1'b1 && n < 40) begin cycle(); n++; end
      total++; if (n != 16) $display("FAIL midload_rst_len got=%0d want=16", n); else passed++;
   endtask

   task automatic test_random();
      int bad;
      logic [CW-1:0] exp;
      bad = 0;
      for (int i = 0; i < 300; i++) begin
         wr_en   = 1'($urandom_range(0, 1));
         wr_addr = AW'($urandom_range(0, DEPTH - 1));
         wr_data = CW'($urandom);
         rd_addr = (NR*AW)'($urandom);
         restore = ($urandom_range(0, 39) == 0);
         cycle();
         for (int k = 0; k < NR; k++) begin
            exp = (m_left > 0) ? '0 : m_col[k];
            total++;
            if (color[k*CW +: CW] !== exp) begin
               $display("FAIL random_color it=%0d port=%0d got=%h want=%h", i, k, color[k*CW +: CW], exp);
               bad++;
            end else passed++;
         end
         total++;
         if (busy !== (m_left > 0)) $display("FAIL random_busy it=%0d got=%b want=%b", i, busy, (m_left > 0));
         else passed++;
      end
      restore = 1'b0; wr_en = 1'b0;
   endtask

   task automatic test_wide();
      logic [CW2-1:0] mb [DEPTH2];
      logic [CW2-1:0] exp [NR2];
      logic [AW2-1:0] ra;
      int n;
      for (int i = 0; i < DEPTH2; i++) mb[i] = (i < 16) ? cga[i][5:0] : 6'h00;
      rst_b = 1'b0;
      n = 0;
      while (busy_b === 1'b1 && n < 80) begin @(posedge clk); #1; n++; end
      total++; if (n != 32) $display("FAIL wide_load_len got=%0d want=32", n); else passed++;
      rd_addr_b = {5'd0, 5'd15, 5'd20, 5'd4};
      @(posedge clk); #1;
      total++; if (color_b[5:0] !== 6'h20) $display("FAIL wide_idx4 got=%h want=20", color_b[5:0]); else passed++;
      total++; if (color_b[11:6] !== 6'h00) $display("FAIL wide_idx20 got=%h want=00", color_b[11:6]); else passed++;
      total++; if (color_b[17:12] !== 6'h3F) $display("FAIL wide_idx15 got=%h want=3f", color_b[17:12]); else passed++;
      total++; if (color_b[23:18] !== 6'h00) $display("FAIL wide_idx0 got=%h want=00", color_b[23:18]); else passed++;
      for (int i = 0; i < 60; i++) begin
         wr_en_b   = 1'($urandom_range(0, 1));
         wr_addr_b = AW2'($urandom_range(0, DEPTH2 - 1));
         wr_data_b = CW2'($urandom);
         rd_addr_b = (NR2*AW2)'($urandom);
         for (int k = 0; k < NR2; k++) begin
            ra = rd_addr_b[k*AW2 +: AW2];
            exp[k] = (wr_en_b && wr_addr_b == ra) ? wr_data_b : mb[ra];
         end
         if (wr_en_b) mb[wr_addr_b] = wr_data_b;
         @(posedge clk); #1;
         for (int k = 0; k < NR2; k++) begin
            total++;
            if (color_b[k*CW2 +: CW2] !== exp[k])
               $display("FAIL wide_random it=%0d port=%0d got=%h want=%h", i, k, color_b[k*CW2 +: CW2], exp[k]);
            else passed++;
         end
      end
      wr_en_b = 1'b0;
   endtask

   initial begin
      rst_b = 1'b1; restore_b = 1'b0; wr_en_b = 1'b0; wr_addr_b = '0; wr_data_b = '0; rd_addr_b = '0;
      test_reset();
      test_bypass();
      test_write_during_load();
      test_restore();
      test_restore_collide();
      test_random();
      test_wide();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1);
   end

endmodule
